// File: rtl/ram_arbiter_pkg.sv
// Shared encodings and default widths for the two-requester RAM arbiter.
// No logic; no latency.
// No backpressure.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester handshake and RAM pin bundle shared by the arbiter and its users.
// No logic; no latency.
// Requesters hold req until ack; the ack cycle is the only completion signal.
interface ram_arbiter_if #(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = ram_arb_pkg::DATA_W_DEF
);

  logic              req0, req1;
  logic              rwN0, rwN1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              lock0, lock1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        gnt;
  logic              ram_readWriteN;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  modport slave (
    input  req0, req1, rwN0, rwN1, addr0, addr1, wdata0, wdata1,
    input  lock0, lock1, ram_data_out,
    output ack0, ack1, rdata, gnt, ram_readWriteN, ram_address, ram_data_in
  );

  modport master (
    output req0, req1, rwN0, rwN1, addr0, addr1, wdata0, wdata1,
    output lock0, lock1, ram_data_out,
    input  ack0, ack1, rdata, gnt, ram_readWriteN, ram_address, ram_data_in
  );

endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the side that did not win last wins.
// Zero latency.
// No backpressure; valid is simply "any request".
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] winner,
  output logic       valid
);

  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last_grant ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port RAM between CPU (0) and debug (1); RAM_ARB_LOCK_EN enables owner lock.
// Latency: req in cycle N, RAM access N+1, ack + rdata N+2; one transaction per 2 cycles.
// Requesters wait with req held until their ack; the losing side simply stays pending.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic           clk,
  input  logic           resetN,
  ram_arbiter_if.slave   bus
);

  state_t            state_q, state_d;
  logic              owner_q;
  logic              last_grant_q;
  logic [1:0]        gnt_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        req_vec;
  logic [1:0]        pick_win;
  logic              pick_vld;
  logic              pick_id;
  logic              lock_hold;
  logic              grant_en;
  logic              grant_id;
  logic              upd_last;
  logic [DATA_W-1:0] resp_data;

  assign req_vec = {bus.req1, bus.req0};

  rr_pick2 u_pick (
    .req        (req_vec),
    .last_grant (last_grant_q),
    .winner     (pick_win),
    .valid      (pick_vld)
  );

  assign pick_id = (pick_win == 2'b10);

`ifdef RAM_ARB_LOCK_EN
  // Owner keeps the RAM when it asks again with lock set; fairness state untouched.
  assign lock_hold = (state_q == ST_RESP) &&
                     ((owner_q == REQ_DBG) ? (bus.lock1 && bus.req1)
                                           : (bus.lock0 && bus.req0));
`else
  wire unused_lock = bus.lock0 | bus.lock1;
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    grant_id = owner_q;
    upd_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_en = 1'b1;
          grant_id = pick_id;
          upd_last = 1'b1;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        if (lock_hold) begin
          grant_en = 1'b1;
          grant_id = owner_q;
          state_d  = ST_ACCESS;
        end else if (pick_vld) begin
          grant_en = 1'b1;
          grant_id = pick_id;
          upd_last = 1'b1;
          state_d  = ST_ACCESS;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      owner_q      <= REQ_CPU;
      last_grant_q <= 1'b1;
      gnt_q        <= 2'b00;
      rw_q         <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        owner_q <= grant_id;
        gnt_q   <= (grant_id == REQ_DBG) ? 2'b10 : 2'b01;
        rw_q    <= (grant_id == REQ_DBG) ? bus.rwN1   : bus.rwN0;
        addr_q  <= (grant_id == REQ_DBG) ? bus.addr1  : bus.addr0;
        wdata_q <= (grant_id == REQ_DBG) ? bus.wdata1 : bus.wdata0;
      end else if (state_q == ST_RESP) begin
        gnt_q <= 2'b00;
      end
      if (upd_last) last_grant_q <= grant_id;
      if (state_q == ST_RESP) rdata_q <= resp_data;
    end
  end

  // RAM output is registered, so during RESP it reflects the ACCESS-cycle address.
  assign resp_data          = rw_q ? bus.ram_data_out : '0;
  assign bus.rdata          = (state_q == ST_RESP) ? resp_data : rdata_q;
  assign bus.ack0           = (state_q == ST_RESP) && (owner_q == REQ_CPU);
  assign bus.ack1           = (state_q == ST_RESP) && (owner_q == REQ_DBG);
  assign bus.gnt            = gnt_q;
  assign bus.ram_readWriteN = (state_q == ST_ACCESS) ? rw_q : 1'b1;
  assign bus.ram_address    = addr_q;
  assign bus.ram_data_in    = wdata_q;

endmodule
